// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller for an in-order pipeline: tracks in-flight destinations in a
// shift-register scoreboard and drives ID stall, EX bubble, IF/ID flush and EX forwarding selects.
module hazard_fwd_unit #(
    parameter int REG_IDX_W   = 5,
    parameter int PIPE_DEPTH  = 3,
    parameter int LD_RDY_SLOT = 2,
    parameter int ZERO_REG    = 1,
    parameter int CNT_W       = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              id_valid,
    input  logic [REG_IDX_W-1:0]              id_rs1,
    input  logic                              id_rs1_used,
    input  logic [REG_IDX_W-1:0]              id_rs2,
    input  logic                              id_rs2_used,
    input  logic [REG_IDX_W-1:0]              id_rd,
    input  logic                              id_wr_en,
    input  logic                              id_is_load,
    input  logic                              br_taken,
    input  logic                              mem_stall,
    output logic                              stall_id,
    output logic                              bubble_ex,
    output logic                              flush_if_id,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_a_sel,
    output logic [$clog2(PIPE_DEPTH+1)-1:0]   fwd_b_sel,
    output logic [CNT_W-1:0]                  stall_cnt,
    output logic [CNT_W-1:0]                  flush_cnt
);

    localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

    logic [PIPE_DEPTH-1:0] slot_v;
    logic [PIPE_DEPTH-1:0] slot_ld;
    logic [REG_IDX_W-1:0]  slot_rd [PIPE_DEPTH];

    logic [REG_IDX_W-1:0]  src_rs   [2];
    logic [1:0]            src_used;
    logic [1:0]            src_hit;
    logic [1:0]            src_ld;
    logic [1:0]            src_hz;
    int                    src_age  [2];
    logic [SEL_W-1:0]      src_sel  [2];

    logic hazard;
    logic hz_go;
    logic br_go;
    logic id_ent_v;

    assign src_rs[0]   = id_rs1;
    assign src_rs[1]   = id_rs2;
    assign src_used[0] = id_rs1_used;
    assign src_used[1] = id_rs2_used;

    // Youngest matching producer wins: scan oldest to youngest so the lowest slot overwrites.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            src_hit[s] = 1'b0;
            src_ld[s]  = 1'b0;
            src_age[s] = 0;
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                if (slot_v[k] && (slot_rd[k] == src_rs[s])) begin
                    src_hit[s] = 1'b1;
                    src_ld[s]  = slot_ld[k];
                    src_age[s] = k;
                end
            end
            if (!(id_valid && src_used[s] && !((ZERO_REG != 0) && (src_rs[s] == '0))))
                src_hit[s] = 1'b0;
            // Producer moves one slot while the consumer enters EX, hence age+1.
            src_hz[s]  = src_hit[s] && ((src_age[s] + 1) < (src_ld[s] ? LD_RDY_SLOT : 1));
            src_sel[s] = (src_hit[s] && ((src_age[s] + 1) <= (PIPE_DEPTH - 1)))
                       ? SEL_W'(src_age[s] + 1) : '0;
        end
    end

    assign hazard      = |src_hz;
    assign br_go       = br_taken && !mem_stall;
    assign hz_go       = hazard && !mem_stall && !br_taken;
    assign flush_if_id = br_go;
    assign stall_id    = mem_stall || hz_go;
    assign bubble_ex   = br_go || hz_go;
    assign id_ent_v    = id_valid && id_wr_en && !((ZERO_REG != 0) && (id_rd == '0));

    // Scoreboard advance / EX entry boundary (control state)
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v    <= '0;
            fwd_a_sel <= '0;
            fwd_b_sel <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (!mem_stall) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--)
                slot_v[k] <= slot_v[k-1];
            slot_v[0] <= id_ent_v && !bubble_ex;
            fwd_a_sel <= bubble_ex ? '0 : src_sel[0];
            fwd_b_sel <= bubble_ex ? '0 : src_sel[1];
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, hz_go};
            flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, br_go};
        end
    end

    // Scoreboard advance boundary (payload, qualified by slot_v)
    always_ff @(posedge clk) begin
        if (!mem_stall) begin
            for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
                slot_rd[k] <= slot_rd[k-1];
                slot_ld[k] <= slot_ld[k-1];
            end
            slot_rd[0] <= id_rd;
            slot_ld[0] <= id_is_load;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: default (depth 3) and deep (depth 4, load ready at slot 3) instances
// share stimulus and are checked against an in-bench age-based scoreboard model.
module tb_hazard_fwd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used, id_wr_en, id_is_load;
    logic        br_taken, mem_stall;

    logic        u3_stall, u3_bub, u3_flush;
    logic [1:0]  u3_sa, u3_sb;
    logic [31:0] u3_sc, u3_fc;
    logic        u4_stall, u4_bub, u4_flush;
    logic [2:0]  u4_sa, u4_sb;
    logic [31:0] u4_sc, u4_fc;

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .mem_stall(mem_stall),
        .stall_id(u3_stall), .bubble_ex(u3_bub), .flush_if_id(u3_flush),
        .fwd_a_sel(u3_sa), .fwd_b_sel(u3_sb), .stall_cnt(u3_sc), .flush_cnt(u3_fc)
    );

    hazard_fwd_unit #(.PIPE_DEPTH(4), .LD_RDY_SLOT(3)) u_dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used), .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
        .br_taken(br_taken), .mem_stall(mem_stall),
        .stall_id(u4_stall), .bubble_ex(u4_bub), .flush_if_id(u4_flush),
        .fwd_a_sel(u4_sa), .fwd_b_sel(u4_sb), .stall_cnt(u4_sc), .flush_cnt(u4_fc)
    );

    int n_chk = 0;
    int n_err = 0;

    // Model: per instance, list of in-flight instructions indexed by age past ID.
    typedef struct { bit v; int rd; bit ld; } ent_t;
    ent_t sb [2][4];
    int   m_sa [2], m_sb [2], m_sc [2], m_fc [2];
    bit   known = 1'b0;

    function automatic int dep(int i);
        return (i == 0) ? 3 : 4;
    endfunction

    function automatic int rdy(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Cycles the consumer would have to wait, and the slot it reads from once in EX.
    function automatic void src_eval(input int i, input int rs, input bit used,
                                     output int wait_c, output int sel);
        wait_c = 0;
        sel    = 0;
        if (!(id_valid && used && rs != 0)) return;
        for (int k = 0; k < dep(i); k++) begin
            if (sb[i][k].v && sb[i][k].rd == rs) begin
                int avail;
                avail  = sb[i][k].ld ? rdy(i) : 1;
                wait_c = (avail - (k + 1) > 0) ? avail - (k + 1) : 0;
                sel    = (k + 1 < dep(i)) ? k + 1 : 0;
                return;
            end
        end
    endfunction

    task automatic sample();
        int wa, wb, sa, sbv;
        bit hz;
        logic [31:0] st, bu, fl, xa, xb, sc, fc;
        @(negedge clk);
        if (!known) return;
        for (int i = 0; i < 2; i++) begin
            src_eval(i, int'(id_rs1), id_rs1_used, wa, sa);
            src_eval(i, int'(id_rs2), id_rs2_used, wb, sbv);
            hz = (wa > 0) || (wb > 0);
            if (i == 0) begin
                st = 32'(u3_stall); bu = 32'(u3_bub); fl = 32'(u3_flush);
                xa = 32'(u3_sa); xb = 32'(u3_sb); sc = u3_sc; fc = u3_fc;
            end else begin
                st = 32'(u4_stall); bu = 32'(u4_bub); fl = 32'(u4_flush);
                xa = 32'(u4_sa); xb = 32'(u4_sb); sc = u4_sc; fc = u4_fc;
            end
            chk($sformatf("m%0d_stall_id", i), st, 32'(mem_stall || (!br_taken && hz)));
            chk($sformatf("m%0d_bubble_ex", i), bu, 32'(!mem_stall && (br_taken || hz)));
            chk($sformatf("m%0d_flush", i), fl, 32'(!mem_stall && br_taken));
            chk($sformatf("m%0d_fwd_a", i), xa, 32'(m_sa[i]));
            chk($sformatf("m%0d_fwd_b", i), xb, 32'(m_sb[i]));
            chk($sformatf("m%0d_stall_cnt", i), sc, 32'(m_sc[i]));
            chk($sformatf("m%0d_flush_cnt", i), fc, 32'(m_fc[i]));
        end
    endtask

    task automatic tick();
        int wa, wb, sa, sbv;
        bit hz [2];
        int nsa [2], nsb [2];
        bit bub;
        for (int i = 0; i < 2; i++) begin
            src_eval(i, int'(id_rs1), id_rs1_used, wa, sa);
            src_eval(i, int'(id_rs2), id_rs2_used, wb, sbv);
            hz[i]  = (wa > 0) || (wb > 0);
            nsa[i] = sa;
            nsb[i] = sbv;
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = 0; k < 4; k++) sb[i][k].v = 1'b0;
                m_sa[i] = 0; m_sb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
            end else if (known && !mem_stall) begin
                bub = br_taken || hz[i];
                for (int k = dep(i) - 1; k > 0; k--) sb[i][k] = sb[i][k-1];
                sb[i][0].v  = !bub && id_valid && id_wr_en && (id_rd != 0);
                sb[i][0].rd = int'(id_rd);
                sb[i][0].ld = id_is_load;
                m_sa[i] = bub ? 0 : nsa[i];
                m_sb[i] = bub ? 0 : nsb[i];
                if (br_taken) m_fc[i]++;
                else if (hz[i]) m_sc[i]++;
            end
        end
        if (reset) known = 1'b1;
        #1;
    endtask

    task automatic set_id(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wr, bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
        id_rd = 5'(rd); id_wr_en = wr; id_is_load = ld;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        br_taken = 1'b0;
        mem_stall = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        sample();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit vld; int rs1; bit u1; int rs2; bit u2; int rd; bit wr; bit ld; bit br; bit ms;
        bit e_stall; bit e_bub; bit e_flush; int e_sa; int e_sb;
    } vec_t;
    vec_t tbl [12];

    initial begin
        // Depth-3 instance, LD ready at slot 2; e_sa/e_sb are registered values seen this cycle.
        tbl[0]  = '{1, 0,0, 0,0, 5,1,1, 0,0, 0,0,0, 0,0};
        tbl[1]  = '{1, 5,1, 1,1, 6,1,0, 0,0, 1,1,0, 0,0};
        tbl[2]  = '{1, 5,1, 1,1, 6,1,0, 0,0, 0,0,0, 0,0};
        tbl[3]  = '{1, 6,1, 6,1, 4,1,0, 0,0, 0,0,0, 2,0};
        tbl[4]  = '{1, 4,1, 6,1, 0,1,0, 0,0, 0,0,0, 1,1};
        tbl[5]  = '{1, 0,1, 0,1, 7,1,0, 0,0, 0,0,0, 1,2};
        tbl[6]  = '{1, 4,1, 7,1, 8,1,1, 0,0, 0,0,0, 0,0};
        tbl[7]  = '{1, 8,1, 0,0, 9,1,0, 1,0, 0,1,1, 0,1};
        tbl[8]  = '{1, 8,1, 8,0, 9,1,0, 0,0, 0,0,0, 0,0};
        tbl[9]  = '{1, 9,1, 0,0, 3,1,0, 1,1, 1,0,0, 2,0};
        tbl[10] = '{0, 9,1, 0,0, 3,1,0, 0,0, 0,0,0, 2,0};
        tbl[11] = '{1, 9,1, 0,0, 0,1,0, 0,0, 0,0,0, 0,0};

        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        sample();
        chk("rst_fwd_a", 32'(u3_sa), 0);
        chk("rst_fwd_b", 32'(u4_sb), 0);
        chk("rst_stall_cnt", u3_sc, 0);
        chk("rst_flush_cnt", u4_fc, 0);
        chk("rst_stall_id", 32'(u3_stall), 0);
        tick();

        for (int r = 0; r < 12; r++) begin
            set_id(tbl[r].vld, tbl[r].rs1, tbl[r].u1, tbl[r].rs2, tbl[r].u2,
                   tbl[r].rd, tbl[r].wr, tbl[r].ld);
            br_taken  = tbl[r].br;
            mem_stall = tbl[r].ms;
            sample();
            chk($sformatf("tbl%0d_stall", r), 32'(u3_stall), 32'(tbl[r].e_stall));
            chk($sformatf("tbl%0d_bubble", r), 32'(u3_bub), 32'(tbl[r].e_bub));
            chk($sformatf("tbl%0d_flush", r), 32'(u3_flush), 32'(tbl[r].e_flush));
            chk($sformatf("tbl%0d_fwd_a", r), 32'(u3_sa), 32'(tbl[r].e_sa));
            chk($sformatf("tbl%0d_fwd_b", r), 32'(u3_sb), 32'(tbl[r].e_sb));
            tick();
        end
        idle();
        sample();
        chk("tbl_end_fwd_a", 32'(u3_sa), 2);
        chk("tbl_end_stall_cnt", u3_sc, 1);
        chk("tbl_end_flush_cnt", u3_fc, 1);
        tick();

        // Load-use held under a 4-cycle cache stall.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        sample(); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        mem_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            chk($sformatf("ms%0d_stall", c), 32'(u3_stall), 1);
            chk($sformatf("ms%0d_bubble", c), 32'(u3_bub), 0);
            chk($sformatf("ms%0d_stall_cnt", c), u3_sc, 0);
            tick();
        end
        mem_stall = 1'b0;
        sample();
        chk("ms_rel_stall", 32'(u3_stall), 1);
        chk("ms_rel_bubble", 32'(u3_bub), 1);
        tick();
        sample();
        chk("ms_after_stall_cnt", u3_sc, 1);
        chk("ms_after_stall", 32'(u3_stall), 0);
        tick();
        idle();
        sample();
        chk("ms_after_fwd_a", 32'(u3_sa), 2);
        tick();

        // Taken branch overrides a load-use hazard in ID.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        sample(); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        br_taken = 1'b1;
        sample();
        chk("br_flush", 32'(u3_flush), 1);
        chk("br_stall", 32'(u3_stall), 0);
        chk("br_bubble", 32'(u3_bub), 1);
        tick();
        idle();
        sample();
        chk("br_flush_cnt", u3_fc, 1);
        chk("br_stall_cnt", u3_sc, 0);
        tick();

        // Deep instance: two load-use stall cycles, then forward from slot 3.
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        sample(); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        for (int c = 0; c < 3; c++) begin
            sample();
            chk($sformatf("d4_stall%0d", c), 32'(u4_stall), 32'(c < 2));
            tick();
        end
        idle();
        sample();
        chk("d4_fwd_a", 32'(u4_sa), 3);
        chk("d4_stall_cnt", u4_sc, 2);
        tick();

        // Reset in the middle of a stalled hazard.
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        sample(); tick();
        set_id(1, 5, 1, 1, 1, 6, 1, 0);
        mem_stall = 1'b1;
        reset = 1'b1;
        sample(); tick();
        reset = 1'b0;
        sample();
        chk("mrst_stall_cnt", u4_sc, 0);
        chk("mrst_fwd_a", 32'(u4_sa), 0);
        chk("mrst_stall_held", 32'(u4_stall), 1);
        mem_stall = 1'b0;
        sample();
        chk("mrst_d4_no_hz", 32'(u4_stall), 0);
        chk("mrst_d3_no_hz", 32'(u3_stall), 0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 79) == 0);
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0);
            br_taken  = ($urandom_range(0, 9) == 0);
            mem_stall = ($urandom_range(0, 6) == 0);
            sample();
            tick();
        end
        reset = 1'b0;
        idle();
        sample();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
